sliding_bloom_row_ager: RTL
===========================

// Module: sliding_bloom_row_ager
// PURPOSE
//  Pipelined, back-pressured successor to the combinational row-update logic of the time-windowed Bloom filter.
//  Ages one memory row to the current (loop,bucket) time, optionally increments the newest counter, and reports the row total.
//  Sits between the bloom SRAM read port and the write-back path; one row accepted per cycle when not stalled.
//  Adds: modular loop wrap, stale-row detection, saturating increment, always-zero on full expiry.
// PARAMETERS
//  NUM_BUCKETS  14   counters per row; bucket 0 = oldest (row LSBs), bucket NUM_BUCKETS-1 = newest
//  BUCKET_SZ    4    bits per counter
//  LOOP_W       12   loop-stamp width
//  BUCKET_W     log2(NUM_BUCKETS)  bucket-stamp width (4)
//  DATA_WIDTH   NUM_BUCKETS*BUCKET_SZ+BUCKET_W+LOOP_W (72)  row layout {bloom, bucket, loop}, loop in LSBs
//  CNT_W        BUCKET_SZ+log2(NUM_BUCKETS+1) (8)  row-total width
// PORTS
//  clk          in   1           clock
//  reset        in   1           asynchronous, active-low reset
//  in_valid     in   1           request valid
//  in_ready     out  1           block can accept request
//  in_data      in   DATA_WIDTH  row read from bloom memory
//  in_incr      in   1           increment newest bucket after ageing
//  cur_bucket   in   BUCKET_W    current bucket time, sampled with request
//  cur_loop     in   LOOP_W      current loop time, sampled with request
//  out_valid    out  1           result valid
//  out_ready    in   1           downstream accepts result
//  out_data     out  DATA_WIDTH  aged row for write-back
//  out_count    out  CNT_W       sum of all counters in out_data
//  out_stale    out  1           row stamped ahead of current time / bad bucket; row passed unchanged
//  out_sat      out  1           increment requested but newest counter already all-ones
// BEHAVIOUR
//  Reset (async assert, sync release): both stage valids 0, out_data/out_count/out_stale/out_sat 0, in_ready 1; in-flight rows dropped.
//  Handshake: transfer on valid&ready both sides. Stage S1 registers request + shift count; S2 registers result.
//   Stage advances when empty or next stage advances; in_ready = !s1_v | (!s2_v | out_ready). No combinational in_data->out path.
//   Latency: out_valid 2 cycles after accepting transfer with no back-pressure; full throughput 1/cycle; order preserved; no loss/dup.
//   out_* held stable while out_valid & !out_ready.
//  S1 shift count: d = (cur_loop - data_loop) mod 2^LOOP_W (wrap-around legal).
//   d==0, cur_bucket>=data_bucket: sh = cur_bucket-data_bucket.
//   d==0, cur_bucket<data_bucket: stale.
//   d==1: sh = min(NUM_BUCKETS, NUM_BUCKETS-data_bucket+cur_bucket).
//   2 <= d < 2^(LOOP_W-1): sh = NUM_BUCKETS (row expired).
//   d >= 2^(LOOP_W-1): stale (data ahead of time).
//   cur_bucket or data_bucket >= NUM_BUCKETS: stale.
//  S2 ageing: bloom >> (sh*BUCKET_SZ), zero-filled from newest end; sh>=NUM_BUCKETS gives all-zero bloom.
//   Then if in_incr: newest counter +1, saturating at 2^BUCKET_SZ-1; out_sat=1 only if it was already saturated.
//   Time fields: out bucket=cur_bucket, out loop=cur_loop.
//  Stale: out_data = in_data unchanged (no increment), out_stale=1, out_sat=0; out_count still summed.
//  out_count: unsigned sum of all NUM_BUCKETS counters of final out_data, no overflow by CNT_W choice.
//  Shifter and adder are parametric (loop/generate); no per-value case tables.
// TESTING
//  Bloom of all 1-counters, row (b3,l5), cur (b5,l5), incr=0 -> bloom 56'h0011_1111_1111_11, stamp (5,5), count 12, out_valid at cycle+2.
//  Row (b10,l7), cur (b2,l8) all ones -> sh=6, bloom 56'h0000_0011_1111_11, count 8.
//  Row (b13,l0xFFF), cur (b0,l0x000) -> wrap d=1, sh=1, count 13, stale 0.
//  Row l=3 of all F, cur l=6, incr=1 -> bloom 56'h1000_0000_0000_00, count 1.
//   Then newest=F, sh=0, incr=1 -> unchanged, out_sat=1.
//  Row l=9, cur l=8 -> out_data==in_data, out_stale=1; also cur_bucket=14 -> stale.
//  Stream 4 rows, out_ready low 5 cycles -> in_ready drops after 2 held; all 4 emerge in order.
//   reset low mid-stream -> out_valid 0 immediately, in_ready 1.

Source files
------------

// File: rtl/sliding_bloom_row_ager.sv
// Two-stage row ager for the time-windowed Bloom filter: S1 derives the bucket shift from the
// time stamps, S2 ages/increments the row and totals its counters. Valid/ready on both sides.
module sliding_bloom_row_ager #(
   parameter int NUM_BUCKETS = 14,
   parameter int BUCKET_SZ   = 4,
   parameter int LOOP_W      = 12,
   parameter int BUCKET_W    = $clog2(NUM_BUCKETS),
   parameter int DATA_WIDTH  = NUM_BUCKETS*BUCKET_SZ + BUCKET_W + LOOP_W,
   parameter int CNT_W       = BUCKET_SZ + $clog2(NUM_BUCKETS+1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_incr,
   input  logic [BUCKET_W-1:0]   cur_bucket,
   input  logic [LOOP_W-1:0]     cur_loop,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]      out_count,
   output logic                  out_stale,
   output logic                  out_sat
);

   localparam int BLOOM_W = NUM_BUCKETS*BUCKET_SZ;
   localparam int SH_W    = $clog2(NUM_BUCKETS+1);
   localparam int SHAMT_W = $clog2(BLOOM_W+1);

   localparam logic [BUCKET_W:0]   NB_B      = (BUCKET_W+1)'(NUM_BUCKETS);
   localparam logic [BUCKET_W+1:0] NB_W      = (BUCKET_W+2)'(NUM_BUCKETS);
   localparam logic [SH_W-1:0]     NB_SH     = SH_W'(NUM_BUCKETS);
   localparam logic [LOOP_W-1:0]   LOOP_ZERO = {LOOP_W{1'b0}};
   localparam logic [LOOP_W-1:0]   LOOP_ONE  = LOOP_W'(1);
   localparam logic [BUCKET_SZ-1:0] CNT_MAX  = {BUCKET_SZ{1'b1}};
   localparam logic [BUCKET_SZ-1:0] CNT_ONE  = BUCKET_SZ'(1);

   // ---------------------------------------------------------------- handshake
   logic s1_v_q;
   logic out_v_q;
   logic s2_adv_s;
   logic s1_adv_s;

   assign s2_adv_s = !out_v_q || out_ready;
   assign s1_adv_s = !s1_v_q || s2_adv_s;
   assign in_ready = s1_adv_s;

   // ---------------------------------------------------------------- stage 1
   logic [BLOOM_W-1:0]  in_bloom_s;
   logic [BUCKET_W-1:0] in_bucket_s;
   logic [LOOP_W-1:0]   in_loop_s;
   logic [LOOP_W-1:0]   dloop_s;
   logic [BUCKET_W+1:0] wrap_sh_s;
   logic [SH_W-1:0]     s1_sh_d;
   logic                s1_stale_d;

   assign {in_bloom_s, in_bucket_s, in_loop_s} = in_data;
   assign dloop_s   = cur_loop - in_loop_s;
   // Shift when the row was written one loop earlier: remaining buckets of that loop plus elapsed ones.
   assign wrap_sh_s = NB_W - {2'b00, in_bucket_s} + {2'b00, cur_bucket};

   // Shift count and stale classification from the row stamp versus current time.
   always_comb begin
      s1_sh_d    = {SH_W{1'b0}};
      s1_stale_d = 1'b0;
      if (({1'b0, cur_bucket} >= NB_B) || ({1'b0, in_bucket_s} >= NB_B)) begin
         s1_stale_d = 1'b1;
      end else if (dloop_s == LOOP_ZERO) begin
         if (cur_bucket >= in_bucket_s) begin
            s1_sh_d = SH_W'(cur_bucket - in_bucket_s);
         end else begin
            s1_stale_d = 1'b1;
         end
      end else if (dloop_s == LOOP_ONE) begin
         if (wrap_sh_s >= NB_W) begin
            s1_sh_d = NB_SH;
         end else begin
            s1_sh_d = SH_W'(wrap_sh_s);
         end
      end else if (!dloop_s[LOOP_W-1]) begin
         s1_sh_d = NB_SH;
      end else begin
         s1_stale_d = 1'b1;
      end
   end

   logic [DATA_WIDTH-1:0] s1_data_q;
   logic [BUCKET_W-1:0]   s1_bucket_q;
   logic [LOOP_W-1:0]     s1_loop_q;
   logic                  s1_incr_q;
   logic [SH_W-1:0]       s1_sh_q;
   logic                  s1_stale_q;

   // Stage 1 register: captures the accepted request and its precomputed shift.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_v_q      <= 1'b0;
         s1_data_q   <= {DATA_WIDTH{1'b0}};
         s1_bucket_q <= {BUCKET_W{1'b0}};
         s1_loop_q   <= {LOOP_W{1'b0}};
         s1_incr_q   <= 1'b0;
         s1_sh_q     <= {SH_W{1'b0}};
         s1_stale_q  <= 1'b0;
      end else if (s1_adv_s) begin
         s1_v_q <= in_valid;
         if (in_valid) begin
            s1_data_q   <= in_data;
            s1_bucket_q <= cur_bucket;
            s1_loop_q   <= cur_loop;
            s1_incr_q   <= in_incr;
            s1_sh_q     <= s1_sh_d;
            s1_stale_q  <= s1_stale_d;
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic [BLOOM_W-1:0]    s1_bloom_s;
   logic [SHAMT_W-1:0]    shamt_s;
   logic [BLOOM_W-1:0]    aged_s;
   logic [BUCKET_SZ-1:0]  newest_s;
   logic [BLOOM_W-1:0]    bloom_fin_s;
   logic                  out_sat_d;
   logic [DATA_WIDTH-1:0] out_data_d;
   logic [CNT_W-1:0]      out_count_d;

   assign s1_bloom_s = s1_data_q[DATA_WIDTH-1 -: BLOOM_W];
   // A shift of NUM_BUCKETS moves every counter out, leaving an all-zero row.
   assign shamt_s    = SHAMT_W'(s1_sh_q) * SHAMT_W'(BUCKET_SZ);
   assign aged_s     = s1_bloom_s >> shamt_s;
   assign newest_s   = aged_s[BLOOM_W-1 -: BUCKET_SZ];

   // Saturating increment of the newest counter; stale rows pass through untouched.
   always_comb begin
      bloom_fin_s = aged_s;
      out_sat_d   = 1'b0;
      if (s1_stale_q) begin
         bloom_fin_s = s1_bloom_s;
      end else if (s1_incr_q) begin
         if (newest_s == CNT_MAX) begin
            out_sat_d = 1'b1;
         end else begin
            bloom_fin_s[BLOOM_W-1 -: BUCKET_SZ] = newest_s + CNT_ONE;
         end
      end else begin
         bloom_fin_s = aged_s;
      end
   end

   // Row total over the final counters.
   always_comb begin
      out_count_d = {CNT_W{1'b0}};
      for (int i = 0; i < NUM_BUCKETS; i++) begin
         out_count_d = out_count_d + CNT_W'(bloom_fin_s[i*BUCKET_SZ +: BUCKET_SZ]);
      end
   end

   // Output word: restamped aged row, or the original row when stale.
   always_comb begin
      if (s1_stale_q) begin
         out_data_d = s1_data_q;
      end else begin
         out_data_d = {bloom_fin_s, s1_bucket_q, s1_loop_q};
      end
   end

   logic [DATA_WIDTH-1:0] out_data_q;
   logic [CNT_W-1:0]      out_count_q;
   logic                  out_stale_q;
   logic                  out_sat_q;

   // Stage 2 register: result word, held while downstream stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_v_q     <= 1'b0;
         out_data_q  <= {DATA_WIDTH{1'b0}};
         out_count_q <= {CNT_W{1'b0}};
         out_stale_q <= 1'b0;
         out_sat_q   <= 1'b0;
      end else if (s2_adv_s) begin
         out_v_q <= s1_v_q;
         if (s1_v_q) begin
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_stale_q <= s1_stale_q;
            out_sat_q   <= out_sat_d;
         end
      end
   end

   assign out_valid = out_v_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign out_stale = out_stale_q;
   assign out_sat   = out_sat_q;

endmodule
